// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div_ctrl divided-clock generator.
package clk_div_pkg;

   localparam int unsigned CNT_W        = 16;
   localparam int unsigned DEFAULT_HALF = 50;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/half_period_counter.sv
// Half-period counter: owns the active half-period and flags the last cycle of a phase.
module half_period_counter
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W        = clk_div_pkg::CNT_W,
   parameter int unsigned DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_half_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;

   // half is never zero, so half-1 cannot underflow; >= keeps the count bounded
   assign tc_o = (cnt_q >= (half_q - CNT_W'(1)));

   always_comb begin
      cnt_d  = cnt_q;
      half_d = half_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : (cnt_q + CNT_W'(1));
      end
      if (load_i) begin
         half_d = load_half_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         half_q <= CNT_W'(DEFAULT_HALF);
      end else begin
         cnt_q  <= cnt_d;
         half_q <= half_d;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty clock divider with run/drain control and a glitch-free config handshake.
module clk_div_ctrl #(
   parameter int unsigned CNT_W        = clk_div_pkg::CNT_W,
   parameter int unsigned DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
   input  logic             clk_100MHz,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             running
);

   import clk_div_pkg::*;

   state_e           state_q, state_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;
   logic             running_q, running_d;
   logic             ready_q, ready_d;
   logic             pending_q, pending_d;
   logic [CNT_W-1:0] pend_half_q, pend_half_d;

   logic             tc;
   logic             active;
   logic             fall;
   logic             accept, bad, good, direct, apply;
   logic             cnt_clear;
   logic             load;
   logic [CNT_W-1:0] load_half;

   half_period_counter #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
   ) u_cnt (
      .clk_i       (clk_100MHz),
      .rst_i       (rst),
      .clear_i     (cnt_clear),
      .en_i        (active),
      .load_i      (load),
      .load_half_i (load_half),
      .tc_o        (tc)
   );

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Every DRAIN exit to IDLE lands on a phase boundary: a falling edge, or the end of a low phase.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en)      state_d = RUN;
            else if (tc) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      active    = (state_q != IDLE);
      cnt_clear = (state_d == IDLE);

      clk_out_d = clk_out_q;
      if (state_d == IDLE) begin
         clk_out_d = 1'b0;
      end else if (active && tc) begin
         clk_out_d = ~clk_out_q;
      end
      tick_d = clk_out_d & ~clk_out_q;
      fall   = clk_out_q & ~clk_out_d;

      // Configs arriving while the clock runs wait for a falling edge so no phase is cut or stretched
      accept = cfg_valid & ready_q;
      bad    = accept & (cfg_half == '0);
      good   = accept & ~bad;
      direct = good & ((state_q == IDLE) | (state_d == IDLE));
      apply  = pending_q & (fall | (state_d == IDLE));

      load      = direct | apply;
      load_half = direct ? cfg_half : pend_half_q;

      pending_d   = pending_q;
      pend_half_d = pend_half_q;
      if (apply) begin
         pending_d = 1'b0;
      end
      if (good && !direct) begin
         pending_d   = 1'b1;
         pend_half_d = cfg_half;
      end

      ready_d   = ~pending_d;
      err_d     = bad;
      running_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         clk_out_q   <= 1'b0;
         tick_q      <= 1'b0;
         err_q       <= 1'b0;
         running_q   <= 1'b0;
         ready_q     <= 1'b1;
         pending_q   <= 1'b0;
         pend_half_q <= '0;
      end else begin
         clk_out_q   <= clk_out_d;
         tick_q      <= tick_d;
         err_q       <= err_d;
         running_q   <= running_d;
         ready_q     <= ready_d;
         pending_q   <= pending_d;
         pend_half_q <= pend_half_d;
      end
   end

   assign clk_out   = clk_out_q;
   assign tick      = tick_q;
   assign cfg_err   = err_q;
   assign running   = running_q;
   assign cfg_ready = ready_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with hand-computed cycle counts.
module tb_clk_div_ctrl;

   localparam int unsigned CNT_W = 16;
   localparam int LIMIT = 300;

   logic             clk_100MHz;
   logic             rst;
   logic             en;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_half;
   logic             cfg_ready;
   logic             cfg_err;
   logic             clk_out;
   logic             tick;
   logic             running;

   int n_checks = 0;
   int n_fail   = 0;
   int n;

   clk_div_ctrl #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (50)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_half   (cfg_half),
      .cfg_ready  (cfg_ready),
      .cfg_err    (cfg_err),
      .clk_out    (clk_out),
      .tick       (tick),
      .running    (running)
   );

   initial begin
      clk_100MHz = 1'b0;
      forever #5 clk_100MHz = ~clk_100MHz;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk_100MHz);
         #1;
      end
   endtask

   // Counts edges until clk_out reaches v; returns LIMIT if it never does.
   task automatic run_until(input logic v, output int cnt);
      cnt = 0;
      do begin
         @(posedge clk_100MHz);
         #1;
         cnt++;
      end while (clk_out !== v && cnt < LIMIT);
   endtask

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_half  = '0;
      step(2);
      check("rst_clk_out", clk_out, 0);
      check("rst_tick", tick, 0);
      check("rst_err", cfg_err, 0);
      check("rst_running", running, 0);
      check("rst_ready", cfg_ready, 1);
      rst = 1'b0;
      step(1);

      // default half 50: first rise 50 edges after en is sampled
      en = 1'b1;
      run_until(1'b1, n); check("dflt_first_rise", n, 51);
      check("dflt_tick", tick, 1);
      check("dflt_running", running, 1);
      run_until(1'b0, n); check("dflt_high", n, 50);
      run_until(1'b1, n); check("dflt_low", n, 50);

      // mid-high reconfigure to 10; extra offers while pending are ignored
      step(20);
      cfg_valid = 1'b1; cfg_half = 16'd10;
      step(1);
      check("cfg_pending_ready", cfg_ready, 0);
      cfg_half = 16'd7;
      step(1);
      cfg_half = 16'd0;
      step(1);
      cfg_valid = 1'b0;
      check("ignored_no_err", cfg_err, 0);
      run_until(1'b0, n); check("cfg_old_high_end", n, 27);
      check("cfg_ready_back", cfg_ready, 1);
      run_until(1'b1, n); check("new_low", n, 10);
      check("new_tick", tick, 1);
      run_until(1'b0, n); check("new_high", n, 10);
      run_until(1'b1, n); check("new_low2", n, 10);

      // zero half rejected
      cfg_valid = 1'b1; cfg_half = 16'd0;
      step(1);
      cfg_valid = 1'b0;
      check("zero_err", cfg_err, 1);
      check("zero_ready", cfg_ready, 1);
      step(1);
      check("zero_err_pulse", cfg_err, 0);
      run_until(1'b0, n); check("zero_high", n, 8);
      run_until(1'b1, n); check("zero_low", n, 10);

      // drop en in high phase: finish the phase, then IDLE
      en = 1'b0;
      step(1);
      check("drain_running", running, 1);
      run_until(1'b0, n); check("drain_fall", n, 9);
      check("drain_idle", running, 0);
      step(2);
      check("idle_quiet", clk_out, 0);

      cfg_valid = 1'b1; cfg_half = 16'd4;
      step(1);
      cfg_valid = 1'b0;
      check("idle_cfg_ready", cfg_ready, 1);
      en = 1'b1;
      run_until(1'b1, n); check("h4_rise", n, 5);
      check("h4_tick", tick, 1);
      step(2);
      en = 1'b0;
      run_until(1'b0, n); check("h4_drain_fall", n, 2);
      check("h4_idle", running, 0);

      // en re-raised in DRAIN keeps phase
      en = 1'b1;
      run_until(1'b1, n); check("h4_rise2", n, 5);
      step(1);
      en = 1'b0;
      step(1);
      check("redrain_running", running, 1);
      en = 1'b1;
      run_until(1'b0, n); check("rerun_fall", n, 2);
      check("rerun_running", running, 1);
      run_until(1'b1, n); check("rerun_rise", n, 4);
      check("rerun_tick", tick, 1);

      // drain entered in low phase completes the low phase only
      run_until(1'b0, n); check("pre_low_fall", n, 4);
      en = 1'b0;
      step(3);
      check("lowdrain_running", running, 1);
      step(1);
      check("lowdrain_idle", running, 0);
      check("lowdrain_clk", clk_out, 0);
      check("lowdrain_tick", tick, 0);

      // pending config applied together with DRAIN->IDLE
      en = 1'b1;
      run_until(1'b1, n); check("h4_rise3", n, 5);
      cfg_valid = 1'b1; cfg_half = 16'd3; en = 1'b0;
      step(1);
      cfg_valid = 1'b0;
      check("both_pending", cfg_ready, 0);
      run_until(1'b0, n); check("both_fall", n, 3);
      check("both_idle", running, 0);
      check("both_ready", cfg_ready, 1);
      en = 1'b1;
      run_until(1'b1, n); check("h3_rise", n, 4);

      // half = 1 from IDLE
      en = 1'b0;
      run_until(1'b0, n); check("h3_fall", n, 3);
      cfg_valid = 1'b1; cfg_half = 16'd1;
      step(1);
      cfg_valid = 1'b0;
      check("h1_idle", running, 0);
      en = 1'b1;
      run_until(1'b1, n); check("h1_rise", n, 2);
      check("h1_tick", tick, 1);
      for (int i = 0; i < 6; i++) begin
         step(1);
         check("h1_clk", clk_out, i % 2);
         check("h1_tick_seq", tick, i % 2);
      end

      // async reset mid high phase
      check("pre_rst_high", clk_out, 1);
      rst = 1'b1;
      #2;
      check("arst_clk", clk_out, 0);
      check("arst_running", running, 0);
      check("arst_ready", cfg_ready, 1);
      check("arst_tick", tick, 0);
      step(3);
      check("rst_hold_clk", clk_out, 0);
      check("rst_hold_tick", tick, 0);
      en = 1'b0;
      rst = 1'b0;
      step(3);
      check("post_rst_clk", clk_out, 0);
      check("post_rst_running", running, 0);
      en = 1'b1;
      step(1);
      check("post_rst_sample", running, 1);
      run_until(1'b1, n); check("post_rst_rise", n, 50);
      check("post_rst_tick", tick, 1);
      run_until(1'b0, n); check("post_rst_high", n, 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
